// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO drain-side word packer.
// Sub-blocks import this to agree on beat layout and FSM encoding.
package fifo_pkg;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_PACK      = 2;
    localparam int DEF_OUT_WIDTH = DEF_IN_WIDTH * DEF_PACK;

    typedef enum logic {
        ACCUM,
        DRAIN
    } pack_state_e;

    typedef struct packed {
        logic [DEF_OUT_WIDTH-1:0] data;
        logic [DEF_PACK-1:0]      keep;
    } beat_t;

endpackage

// File: rtl/fifo_beat_queue.sv
// Two-entry valid/ready skid queue of packed beats.
// The occupancy count is exported so the producer can reserve slots.
module fifo_beat_queue
    import fifo_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  T           push_beat,
    output logic       m_valid,
    input  logic       m_ready,
    output T           head,
    output logic [1:0] count
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;
    logic pop;

    assign m_valid = (count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops FIFO words and packs PACK of them into one wide output beat.
// Flush closes a partial beat and emits it with a truncated keep mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int PACK     = DEF_PACK
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    input  logic [IN_WIDTH-1:0]      fifo_data_out,
    output logic                     fifo_rd_en,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [IN_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     busy
);

    localparam int OUT_WIDTH = IN_WIDTH * PACK;
    localparam int IW        = $clog2(PACK);
    localparam logic [IW-1:0] LAST = IW'(PACK - 1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [PACK-1:0]      keep;
    } lane_beat_t;

    pack_state_e          state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        issue_lane;
    logic                 rd_pend;
    logic                 run;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] acc_cap;
    logic [PACK-1:0]      part_keep;
    logic [1:0]           out_cnt;
    logic                 last_inflight;
    logic                 reserve_ok;
    logic                 cap_last;
    logic                 drain_partial;
    logic                 flush_take;
    logic                 push;
    lane_beat_t           push_beat;
    lane_beat_t           head;

    always_comb begin
        issue_lane = idx;
        if (rd_pend) begin
            issue_lane = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // A last-lane read only issues if its beat is guaranteed a queue slot.
    assign last_inflight = rd_pend && (idx == LAST);
    assign reserve_ok    = (out_cnt == 2'd0) ||
                           (out_cnt == 2'd1 && !last_inflight);

    assign fifo_rd_en = run && (state == ACCUM) && !fifo_empty &&
                        ((issue_lane != LAST) || reserve_ok);

    always_comb begin
        acc_cap = acc;
        if (rd_pend) begin
            acc_cap[idx*IN_WIDTH +: IN_WIDTH] = fifo_data_out;
        end
    end

    always_comb begin
        part_keep = '0;
        for (int k = 0; k < PACK; k++) begin
            part_keep[k] = (k < int'(idx));
        end
    end

    assign cap_last      = rd_pend && (idx == LAST);
    assign drain_partial = (state == DRAIN) && !rd_pend &&
                           (idx != '0) && (out_cnt != 2'd2);
    assign flush_take    = (state == ACCUM) && flush &&
                           !((idx == '0) && !rd_pend && !fifo_rd_en);

    assign push           = cap_last || drain_partial;
    assign push_beat.data = cap_last ? acc_cap : acc;
    assign push_beat.keep = cap_last ? {PACK{1'b1}} : part_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            idx     <= '0;
            rd_pend <= 1'b0;
            run     <= 1'b0;
            acc     <= '0;
        end else begin
            run     <= 1'b1;
            rd_pend <= fifo_rd_en;
            if (cap_last || drain_partial) begin
                idx <= '0;
                acc <= '0;
            end else if (rd_pend) begin
                idx <= idx + 1'b1;
                acc <= acc_cap;
            end
            unique case (state)
                ACCUM: begin
                    if (flush_take) state <= DRAIN;
                end
                DRAIN: begin
                    if (cap_last ||
                        (!rd_pend && ((idx == '0) || (out_cnt != 2'd2))))
                        state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    fifo_beat_queue #(
        .T (lane_beat_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_beat (push_beat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .head      (head),
        .count     (out_cnt)
    );

    assign m_data = head.data;
    assign m_keep = head.keep;
    assign busy   = (idx != '0) || rd_pend || (out_cnt != 2'd0) ||
                    (state == DRAIN);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a 1-cycle-latency FIFO model.
// Each task drives one scenario and checks its own expectations.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [1:0]  m_keep;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_word_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_keep        (m_keep),
        .busy          (busy)
    );

    // FIFO model: pops on rd_en, data appears one cycle later
    logic [15:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    int nrd = 0;
    int underflow = 0;

    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rp == wp) underflow++;
            else begin
                fifo_data_out <= mem[rp % 256];
                rp++;
                nrd++;
            end
        end
    end

    int cyc = 0;
    int nb = 0;
    int nrd_en = 0;
    logic [31:0] got_data [0:63];
    logic [1:0]  got_keep [0:63];
    int          got_cyc  [0:63];

    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) nrd_en++;
        if (m_valid && m_ready && nb < 64) begin
            got_data[nb] = m_data;
            got_keep[nb] = m_keep;
            got_cyc[nb]  = cyc;
            nb++;
        end
    end

    task automatic push_word(input logic [15:0] w);
        mem[wp % 256] = w;
        wp++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wp = rp;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        total++; if (m_keep !== 2'b00) begin bad++; $display("FAIL reset_m_keep got=%b exp=00", m_keep); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b exp=0", fifo_rd_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        push_word(16'h0055);
        repeat (3) @(negedge clk);
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_hold_rd_en got=%0b exp=0", fifo_rd_en); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_m_valid got=%0b exp=0", m_valid); end
        wp = rp;
    endtask

    task automatic test_stream();
        int base;
        int t0;
        int t1;
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        m_ready = 1'b1;
        base = nb;
        t0 = -1;
        t1 = -1;
        rst_n = 1'b1;
        for (int c = 0; c < 60 && (nb - base) < 4; c++) begin
            @(negedge clk);
            if (fifo_rd_en && t0 < 0) t0 = cyc;
            if (m_valid && t1 < 0) t1 = cyc;
        end
        total++; if (nb - base != 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", nb - base); end
        for (int i = 0; i < 4; i++) begin
            exp = {16'(2 * i + 2), 16'(2 * i + 1)};
            total++; if (got_data[base + i] !== exp) begin bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, got_data[base + i], exp); end
            total++; if (got_keep[base + i] !== 2'b11) begin bad++; $display("FAIL stream_keep%0d got=%b exp=11", i, got_keep[base + i]); end
        end
        for (int i = 1; i < 4; i++) begin
            total++; if (got_cyc[base + i] - got_cyc[base + i - 1] != 2) begin bad++; $display("FAIL stream_gap%0d got=%0d exp=2", i, got_cyc[base + i] - got_cyc[base + i - 1]); end
        end
        total++; if (t1 - t0 != 3) begin bad++; $display("FAIL stream_latency got=%0d exp=3", t1 - t0); end
        total++; if (underflow != 0) begin bad++; $display("FAIL stream_underflow got=%0d exp=0", underflow); end
    endtask

    task automatic test_stall();
        int base;
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        m_ready = 1'b0;
        base = nb;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (nb - base != 0) begin bad++; $display("FAIL stall_no_accept got=%0d exp=0", nb - base); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_m_valid got=%0b exp=1", m_valid); end
        total++; if (m_data !== 32'h00020001) begin bad++; $display("FAIL stall_head got=%h exp=00020001", m_data); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en got=%0b exp=0", fifo_rd_en); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b exp=1", busy); end
        m_ready = 1'b1;
        for (int c = 0; c < 40 && (nb - base) < 4; c++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp = {16'(2 * i + 2), 16'(2 * i + 1)};
            total++; if (got_data[base + i] !== exp) begin bad++; $display("FAIL stall_data%0d got=%h exp=%h", i, got_data[base + i], exp); end
        end
        repeat (5) @(negedge clk);
        total++; if (nb - base != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", nb - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle got=%0b exp=0", busy); end
        total++; if (underflow != 0) begin bad++; $display("FAIL stall_underflow got=%0d exp=0", underflow); end
    endtask

    task automatic test_flush_partial();
        int base;
        do_reset();
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        m_ready = 1'b1;
        base = nb;
        rst_n = 1'b1;
        for (int c = 0; c < 20 && (nb - base) < 1; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fpart_busy_pre got=%0b exp=1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 20 && (nb - base) < 2; c++) @(negedge clk);
        total++; if (got_data[base] !== 32'h000B000A) begin bad++; $display("FAIL fpart_data0 got=%h exp=000B000A", got_data[base]); end
        total++; if (got_keep[base] !== 2'b11) begin bad++; $display("FAIL fpart_keep0 got=%b exp=11", got_keep[base]); end
        total++; if (got_data[base + 1] !== 32'h0000000C) begin bad++; $display("FAIL fpart_data1 got=%h exp=0000000C", got_data[base + 1]); end
        total++; if (got_keep[base + 1] !== 2'b01) begin bad++; $display("FAIL fpart_keep1 got=%b exp=01", got_keep[base + 1]); end
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fpart_busy_post got=%0b exp=0", busy); end
        total++; if (nb - base != 2) begin bad++; $display("FAIL fpart_count got=%0d exp=2", nb - base); end
    endtask

    task automatic test_flush_race();
        int base;
        int n0;
        logic found;
        do_reset();
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        m_ready = 1'b1;
        base = nb;
        n0 = nrd;
        found = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd_en && (nrd - n0) == 2) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL frace_rd_c got=%0b exp=1", found); end
        flush = 1'b1;
        push_word(16'h000D);
        @(negedge clk);
        flush = 1'b0;
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL frace_drain_rd got=%0b exp=0", fifo_rd_en); end
        total++; if (nrd - n0 != 3) begin bad++; $display("FAIL frace_reads got=%0d exp=3", nrd - n0); end
        for (int c = 0; c < 20 && (nb - base) < 2; c++) @(negedge clk);
        total++; if (got_data[base] !== 32'h000B000A) begin bad++; $display("FAIL frace_data0 got=%h exp=000B000A", got_data[base]); end
        total++; if (got_data[base + 1] !== 32'h0000000C) begin bad++; $display("FAIL frace_data1 got=%h exp=0000000C", got_data[base + 1]); end
        total++; if (got_keep[base + 1] !== 2'b01) begin bad++; $display("FAIL frace_keep1 got=%b exp=01", got_keep[base + 1]); end
    endtask

    task automatic test_empty();
        int base;
        int r0;
        do_reset();
        m_ready = 1'b1;
        base = nb;
        r0 = nrd_en;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (nb - base != 0) begin bad++; $display("FAIL empty_beats got=%0d exp=0", nb - base); end
        total++; if (nrd_en - r0 != 0) begin bad++; $display("FAIL empty_rd_en got=%0d exp=0", nrd_en - r0); end
        total++; if (underflow != 0) begin bad++; $display("FAIL empty_underflow got=%0d exp=0", underflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy got=%0b exp=0", busy); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL empty_m_valid got=%0b exp=0", m_valid); end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        m_ready = 1'b0;
        base = nb;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b exp=1", m_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%0b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_m_valid got=%0b exp=0", m_valid); end
        total++; if (m_keep !== 2'b00) begin bad++; $display("FAIL rmid_m_keep got=%b exp=00", m_keep); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
        @(negedge clk);
        wp = rp;
        push_word(16'h0011);
        push_word(16'h0022);
        m_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 20 && (nb - base) < 1; c++) @(negedge clk);
        total++; if (got_data[base] !== 32'h00220011) begin bad++; $display("FAIL rmid_data got=%h exp=00220011", got_data[base]); end
        total++; if (got_keep[base] !== 2'b11) begin bad++; $display("FAIL rmid_keep got=%b exp=11", got_keep[base]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_partial();
        test_flush_race();
        test_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
